// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end: fetch packet layout,
// fetch FSM states and the fixed PC increment.
package fetch_unit_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] pc_next;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: keeps the PC, issues one I-cache read at a time and
// presents each returned word as a {pc, ir, pc_next} packet on valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        icache_read_o,
    output logic [31:0] icache_addr_o,
    input  logic [31:0] icache_rdata_i,
    input  logic        icache_resp_i,
    output logic        valid_o,
    output fetch_pkt_t  data_o,
    input  logic        ready_i
);

    fetch_state_t r_state;
    fetch_state_t w_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc;
    logic [31:0]  r_req_addr;
    logic [31:0]  w_req_addr;
    fetch_pkt_t   r_out;
    fetch_pkt_t   w_out;
    logic         r_out_valid;
    logic         w_out_valid;
    logic         r_squash;
    logic         w_squash;

    assign icache_read_o = (r_state == REQ);
    assign icache_addr_o = r_req_addr;
    assign valid_o       = r_out_valid;
    assign data_o        = r_out;

    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_req_addr  = r_req_addr;
        w_out       = r_out;
        w_out_valid = r_out_valid;
        w_squash    = r_squash;

        unique case (r_state)
            IDLE: begin
                w_state = REQ;
                if (flush_i) begin
                    w_out_valid = 1'b0;
                    w_pc        = flush_pc_i;
                    w_req_addr  = flush_pc_i;
                end else begin
                    w_req_addr  = r_pc;
                end
            end
            REQ: begin
                if (flush_i) begin
                    w_pc = flush_pc_i;
                    // An outstanding read cannot be withdrawn; squash its reply instead.
                    if (icache_resp_i) begin
                        w_squash   = 1'b0;
                        w_req_addr = flush_pc_i;
                    end else begin
                        w_squash   = 1'b1;
                    end
                end else if (icache_resp_i) begin
                    if (r_squash) begin
                        w_squash   = 1'b0;
                        w_req_addr = r_pc;
                    end else begin
                        w_out.pc      = r_req_addr;
                        w_out.ir      = icache_rdata_i;
                        w_out.pc_next = r_req_addr + PC_STEP;
                        w_out_valid   = 1'b1;
                        w_pc          = r_req_addr + PC_STEP;
                        w_state       = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush_i) begin
                    w_out_valid = 1'b0;
                    w_pc        = flush_pc_i;
                    w_req_addr  = flush_pc_i;
                    w_state     = REQ;
                end else if (ready_i) begin
                    w_out_valid = 1'b0;
                    w_req_addr  = r_pc;
                    w_state     = REQ;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_squash    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_req_addr  <= w_req_addr;
            r_out       <= w_out;
            r_out_valid <= w_out_valid;
            r_squash    <= w_squash;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by randomized cache latency, ready and flush
// traffic checked against a packet-stream reference model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        icache_read_o;
    logic [31:0] icache_addr_o;
    logic [31:0] icache_rdata_i;
    logic        icache_resp_i;
    logic        valid_o;
    logic [95:0] data_o;
    logic        ready_i;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h4000_0060)) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .icache_read_o  (icache_read_o),
        .icache_addr_o  (icache_addr_o),
        .icache_rdata_i (icache_rdata_i),
        .icache_resp_i  (icache_resp_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .ready_i        (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [95:0] pkt(input logic [31:0] pc, input logic [31:0] ir);
        return {pc, ir, pc + 32'd4};
    endfunction

    // random-phase model and cache state
    logic [31:0] exp_pc;
    logic [31:0] cap_addr;
    logic [95:0] prev_data;
    logic        prev_valid, prev_ready, prev_flush, busy;
    int          lat, idle_cnt, npkts;

    initial begin
        reset_n_i      = 1'b1;
        flush_i        = 1'b0;
        flush_pc_i     = '0;
        icache_rdata_i = '0;
        icache_resp_i  = 1'b0;
        ready_i        = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_read", 96'(icache_read_o), 96'd0);
        chk("rst_valid", 96'(valid_o), 96'd0);
        chk("rst_data", data_o, 96'd0);

        // reset release, first fetch
        reset_n_i = 1'b0;
        @(negedge clk_i);
        chk("first_read", 96'(icache_read_o), 96'd1);
        chk("first_addr", 96'(icache_addr_o), 96'h4000_0060);
        @(negedge clk_i);
        chk("wait_valid", 96'(valid_o), 96'd0);
        icache_resp_i = 1'b1; icache_rdata_i = 32'h0000_0013;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("pkt0_valid", 96'(valid_o), 96'd1);
        chk("pkt0_data", data_o, pkt(32'h4000_0060, 32'h0000_0013));
        chk("pkt0_noread", 96'(icache_read_o), 96'd0);

        // back-pressure in HOLD
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_data", data_o, pkt(32'h4000_0060, 32'h0000_0013));
            chk("hold_noread", 96'(icache_read_o), 96'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("xfer_valid", 96'(valid_o), 96'd0);
        chk("next_addr", 96'(icache_addr_o), 96'h4000_0064);
        chk("next_read", 96'(icache_read_o), 96'd1);

        // flush mid-request
        flush_i = 1'b1; flush_pc_i = 32'h4000_0100;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("squash_addr_kept", 96'(icache_addr_o), 96'h4000_0064);
        icache_resp_i = 1'b1; icache_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("squash_novalid", 96'(valid_o), 96'd0);
        chk("squash_reissue", 96'(icache_addr_o), 96'h4000_0100);
        icache_resp_i = 1'b1; icache_rdata_i = 32'h0010_0093;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("redir_pkt", data_o, pkt(32'h4000_0100, 32'h0010_0093));
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        chk("redir_next", 96'(icache_addr_o), 96'h4000_0104);

        // flush coincident with response
        icache_resp_i = 1'b1; icache_rdata_i = 32'h1111_1111;
        flush_i = 1'b1; flush_pc_i = 32'h4000_0200;
        @(negedge clk_i);
        icache_resp_i = 1'b0; flush_i = 1'b0;
        chk("coinc_novalid", 96'(valid_o), 96'd0);
        chk("coinc_read", 96'(icache_read_o), 96'd1);
        chk("coinc_addr", 96'(icache_addr_o), 96'h4000_0200);
        icache_resp_i = 1'b1; icache_rdata_i = 32'h2222_2222;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("coinc_pkt", data_o, pkt(32'h4000_0200, 32'h2222_2222));

        // flush in HOLD with ready low
        flush_i = 1'b1; flush_pc_i = 32'h4000_0300;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("holdflush_valid", 96'(valid_o), 96'd0);
        chk("holdflush_addr", 96'(icache_addr_o), 96'h4000_0300);
        chk("holdflush_read", 96'(icache_read_o), 96'd1);

        // reset during REQ with stale responses
        reset_n_i = 1'b1; icache_resp_i = 1'b1; icache_rdata_i = 32'h3333_3333;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("midrst_read", 96'(icache_read_o), 96'd0);
        chk("midrst_valid", 96'(valid_o), 96'd0);
        @(negedge clk_i);
        reset_n_i = 1'b0; icache_resp_i = 1'b1;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("restart_valid", 96'(valid_o), 96'd0);
        chk("restart_addr", 96'(icache_addr_o), 96'h4000_0060);
        @(negedge clk_i);
        icache_resp_i = 1'b1; icache_rdata_i = 32'h4444_4444;
        @(negedge clk_i);
        icache_resp_i = 1'b0;
        chk("restart_pkt", data_o, pkt(32'h4000_0060, 32'h4444_4444));
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;

        // randomized phase: the packet stream must follow pc, pc+4, ... restarting at each flush target
        exp_pc = 32'h4000_0064;
        busy = 1'b0; lat = 0; cap_addr = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_flush = 1'b0; prev_data = '0;
        idle_cnt = 0; npkts = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            icache_resp_i = 1'b0;
            if (prev_flush) begin
                chk("r_flush_kill", 96'(valid_o), 96'd0);
            end else if (prev_valid && !prev_ready) begin
                chk("r_hold_valid", 96'(valid_o), 96'd1);
                chk("r_hold_data", data_o, prev_data);
            end
            if (valid_o && !prev_valid) begin
                chk("r_pkt", data_o, pkt(exp_pc, mem_word(exp_pc)));
                chk("r_pkt_noread", 96'(icache_read_o), 96'd0);
                exp_pc = exp_pc + 32'd4;
                npkts++;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (idle_cnt > 100) begin
                chk("r_liveness", 96'(idle_cnt), 96'd0);
                idle_cnt = 0;
            end

            if (!busy && icache_read_o) begin
                busy = 1'b1;
                cap_addr = icache_addr_o;
                lat = $urandom_range(0, 3);
            end else if (busy) begin
                chk("r_addr_stable", 96'(icache_addr_o), 96'(cap_addr));
                chk("r_read_held", 96'(icache_read_o), 96'd1);
            end
            if (busy) begin
                if (lat == 0) begin
                    icache_resp_i  = 1'b1;
                    icache_rdata_i = mem_word(cap_addr);
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end

            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                flush_pc_i = 32'hFFFF_FFFC;
            else
                flush_pc_i = 32'h4000_0000 + ($urandom & 32'h0000_0FFC);
            if (flush_i)
                exp_pc = flush_pc_i;

            prev_valid = valid_o;
            prev_ready = ready_i;
            prev_flush = flush_i;
            prev_data  = data_o;
        end
        flush_i = 1'b0;
        chk("r_pkt_count_ok", 96'(npkts >= 50), 96'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the out-of-order RV32I core. It holds the PC and issues one I-cache read at a time. Each returned word is presented with its PC as a fetch packet on a valid-ready output that feeds the stateless decoder and then the instruction-queue input. On a mispredict flush it redirects to the flush target and squashes any response still in flight.

## Interface
Parameters:
- RESET_PC, 32'h4000_0060, PC of the first fetch after reset.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_n_i  input  1  reset, synchronous and active-high (asserted = 1) despite the name.
- flush_i  input  1  mispredict redirect, one-cycle pulse.
- flush_pc_i  input  32  redirect target, valid with flush_i.
- icache_read_o  output  1  I-cache read request, held high until icache_resp_i.
- icache_addr_o  output  32  request address, stable while icache_read_o=1.
- icache_rdata_i  input  32  returned instruction word, valid with icache_resp_i.
- icache_resp_i  input  1  one-cycle response pulse.
- valid_o  output  1  fetch packet valid.
- data_o  output  $bits(fetch_pkt_t)  fetch packet {pc, ir, pc_next}.
- ready_i  input  1  downstream ready; the decoder passes the queue's ready_o through combinationally.

## Operation
- State fetch_state_t: IDLE, REQ, HOLD.
- Registers: pc_r (next address to fetch), req_addr_r, out_r (fetch_pkt_t), out_valid_r, squash_r.
- Fixed outputs:
  - icache_read_o = (state==REQ).
  - icache_addr_o = req_addr_r.
  - valid_o = out_valid_r.
  - data_o = out_r.
- IDLE: entered only from reset. Next cycle: req_addr_r<=pc_r, go to REQ.
- REQ, no response: wait. At most one request is outstanding, and out_valid_r=0 throughout REQ.
- REQ, icache_resp_i=1, no squash_r, no flush_i:
  - out_r<={pc:req_addr_r, ir:icache_rdata_i, pc_next:req_addr_r+4}, out_valid_r<=1.
  - pc_r<=req_addr_r+4.
  - Go to HOLD.
- REQ, icache_resp_i=1 with squash_r=1: drop the word, squash_r<=0, req_addr_r<=pc_r, stay in REQ. This reissues at the redirected PC.
- HOLD: out_valid_r=1.
  - If ready_i=1: the transfer completes, out_valid_r<=0, req_addr_r<=pc_r, go to REQ.
  - Otherwise hold data_o stable.
- No prediction: pc_next is always pc+4. PC arithmetic wraps modulo 2^32.
- Flush has priority over every other event:
  - IDLE or HOLD: out_valid_r<=0, pc_r<=flush_pc_i, req_addr_r<=flush_pc_i, go to REQ.
  - REQ, no response this cycle: pc_r<=flush_pc_i, squash_r<=1, stay in REQ. req_addr_r is unchanged because the cache request cannot be withdrawn.
  - REQ with response this cycle: drop the word, squash_r<=0, pc_r<=flush_pc_i, req_addr_r<=flush_pc_i, stay in REQ. The new request starts next cycle.
  - Repeated flushes during one outstanding request: the last flush_pc_i wins, and one squash covers all of them.
  - Flush in HOLD while ready_i=1: the transfer still completes downstream that cycle. The queue flushes on the same pulse and discards it.
- Reset mid-request: state<=IDLE and all registers reset; a cache response arriving during or after reset is ignored.

## Timing
- Reset values: state=IDLE, pc_r=RESET_PC, req_addr_r=RESET_PC, out_valid_r=0, squash_r=0, out_r=0.
- Output values during reset: icache_read_o=0, valid_o=0, data_o=0.
- First icache_read_o is asserted 2 cycles after reset deasserts (IDLE, then REQ).
- Response at cycle N gives valid_o=1 at N+1.
- Transfer at cycle M with ready_i=1 gives the next request at M+1.
- Redirect: flush in HOLD or IDLE at cycle F gives icache_addr_o=flush_pc_i at F+1.
- Throughput: at most one packet per (cache latency + 2) cycles.

## Structure
- rv32i_types additions:
  - fetch_pkt_t packed struct {logic [31:0] pc; logic [31:0] ir; logic [31:0] pc_next;}.
  - fetch_state_t enum {IDLE, REQ, HOLD}.
- Single module, no sub-modules.
- Keep next-state and next-PC logic in one always_comb, with registers in one always_ff.

## Test plan
- Reset release, cache responds 0x00000013 two cycles after request → icache_addr_o=0x40000060; next valid_o=1 with pc=0x40000060, ir=0x00000013, pc_next=0x40000064; next request at 0x40000064.
- ready_i=0 for 5 cycles in HOLD → data_o stable, icache_read_o=0 throughout; ready_i=1 → request at pc+4 next cycle.
- flush_i with flush_pc_i=0x40000100 mid-request to 0x40000064 → that response is not emitted; next icache_addr_o=0x40000100; emitted packet has pc=0x40000100.
- flush_i coincident with icache_resp_i → word dropped; request to flush_pc_i the next cycle; valid_o stays 0.
- flush_i in HOLD with valid_o=1 and ready_i=0 → valid_o=0 next cycle, then request to flush_pc_i.
- reset_n_i=1 during REQ, stale icache_resp_i during reset → no valid_o; fetch restarts at 0x40000060 after release.
